// File: rtl/tf_stage_sequencer_pkg.sv
// ============================================================================
//  Module      : tf_stage_sequencer_pkg
//  Description : Shared FSM states, mode encodings and loop constants for the
//                NTT/INTT stage sequencer and its twiddle-group decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tf_stage_sequencer_pkg;

    localparam int P_MAX         = 9;
    localparam int CYC_W         = 6;
    localparam int CYC_PER_STAGE = 1 << CYC_W;
    localparam int DRAIN_CYC     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam logic [2:0] CONF_NTT     = 3'b001;
    localparam logic [2:0] CONF_NTT_ALT = 3'b100;
    localparam logic [2:0] CONF_INTT    = 3'b010;

    // Both forward encodings walk stages high-to-low; everything else is inverse.
    function automatic logic is_ntt(input logic [2:0] c);
        return (c == CONF_NTT) || (c == CONF_NTT_ALT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tf_k_decode.sv
// ============================================================================
//  Module      : tf_k_decode
//  Description : Maps {issue cycle, stage} to the twiddle group index k.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tf_k_decode #(
    parameter int CYC_W = 6
) (
    input  logic [CYC_W-1:0] cyc,
    input  logic [3:0]       p,
    output logic [CYC_W-1:0] k
);

    // Wide stages span several cycles per group; narrow stages cover several
    // groups per cycle, so k just follows the cycle count there.
    always_comb begin
        k = cyc;
        if (p >= 4'd3) begin
            k = cyc >> (p - 4'd3);
        end
    end

endmodule

`default_nettype wire

// File: rtl/tf_stage_sequencer.sv
// ============================================================================
//  Module      : tf_stage_sequencer
//  Description : Walks all transform stages/groups, issuing {conf,p,k} to the
//                twiddle-address generator with valid/busy/done status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tf_stage_sequencer #(
    parameter int P_MAX     = tf_stage_sequencer_pkg::P_MAX,
    parameter int CYC_W     = tf_stage_sequencer_pkg::CYC_W,
    parameter int DRAIN_CYC = tf_stage_sequencer_pkg::DRAIN_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       conf_in,
    input  logic             stall,
    output logic [2:0]       conf,
    output logic [3:0]       p,
    output logic [CYC_W-1:0] k,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    import tf_stage_sequencer_pkg::*;

    localparam int                DR_W      = $clog2(DRAIN_CYC + 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = {CYC_W{1'b1}};
    localparam logic [3:0]        P_TOP     = 4'(P_MAX);
    localparam logic [DR_W-1:0]   DR_LOAD   = DR_W'(DRAIN_CYC - 1);

    seq_state_t       r_state;
    logic             r_ntt;
    logic [3:0]       r_p;
    logic [CYC_W-1:0] r_cyc;
    logic [DR_W-1:0]  r_drain;
    logic [CYC_W-1:0] w_k;
    logic [3:0]       w_p_last;

    tf_k_decode #(
        .CYC_W (CYC_W)
    ) u_k_decode (
        .cyc (r_cyc),
        .p   (r_p),
        .k   (w_k)
    );

    assign w_p_last = r_ntt ? 4'd0 : P_TOP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ntt   <= 1'b0;
            r_p     <= 4'd0;
            r_cyc   <= '0;
            r_drain <= '0;
            conf    <= 3'd0;
            p       <= 4'd0;
            k       <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A start overlapping the done pulse belongs to the old run.
                    if (start && !done) begin
                        r_state <= ST_RUN;
                        conf    <= conf_in;
                        r_ntt   <= is_ntt(conf_in);
                        r_p     <= is_ntt(conf_in) ? P_TOP : 4'd0;
                        r_cyc   <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    p     <= r_p;
                    k     <= w_k;
                    valid <= !stall;
                    if (!stall) begin
                        r_cyc <= r_cyc + 1'b1;
                        if (r_cyc == CYC_LAST) begin
                            if (r_p == w_p_last) begin
                                r_state <= ST_DRAIN;
                                r_drain <= DR_LOAD;
                            end else begin
                                r_p <= r_ntt ? (r_p - 4'd1) : (r_p + 4'd1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    valid <= 1'b0;
                    if (r_drain == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
